// File: rtl/mem_rsp_pkg.sv
// Shared requester-select type and constants for the memory request/response path.
package mem_rsp_pkg;

    typedef logic rsp_sel_t;

    localparam rsp_sel_t SEL_FETCH = 1'b0;
    localparam rsp_sel_t SEL_DATA  = 1'b1;

    // An output register can take a new response when it is empty or draining this cycle.
    function automatic logic port_can_load(input logic vld, input logic rdy);
        return !vld || rdy;
    endfunction

endpackage

// File: rtl/mem_rsp_demux_tag_fifo.sv
// In-order tag FIFO with a count-based occupancy so full and empty never alias.
module tag_fifo #(
    parameter  int W     = 1,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO only lands when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/mem_rsp_demux.sv
// Steers shared-memory read responses to fetch (port 0) or data (port 1) in issue order.
// Optional protocol checking is built when MEM_RSP_DEMUX_CHECK_EN is defined.
module mem_rsp_demux
    import mem_rsp_pkg::*;
#(
    parameter  int n     = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_fire,
    input  logic          req_sel,
    output logic          tag_full,
    input  logic          rsp_valid,
    input  logic [n-1:0]  rsp_data,
    output logic          rsp_ready,
    output logic          out0_valid,
    output logic [n-1:0]  out0_data,
    input  logic          out0_ready,
    output logic          out1_valid,
    output logic [n-1:0]  out1_data,
    input  logic          out1_ready,
    output logic [CW-1:0] outstanding,
    output logic          error
);

    rsp_sel_t head;
    logic     fifo_empty;
    logic     head_can_load;
    logic     accept;

    tag_fifo #(
        .W     (1),
        .DEPTH (DEPTH)
    ) u_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (accept),
        .din   (req_sel),
        .head  (head),
        .count (outstanding),
        .full  (tag_full),
        .empty (fifo_empty)
    );

    // rsp_ready depends only on tag state and consumer readiness, never on rsp_valid.
    assign head_can_load = (head == SEL_DATA) ? port_can_load(out1_valid, out1_ready)
                                              : port_can_load(out0_valid, out0_ready);
    assign rsp_ready     = !fifo_empty && head_can_load;
    assign accept        = rsp_valid && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out0_valid <= 1'b0;
            out0_data  <= '0;
            out1_valid <= 1'b0;
            out1_data  <= '0;
        end else begin
            if (accept && head == SEL_FETCH) begin
                out0_valid <= 1'b1;
                out0_data  <= rsp_data;
            end else if (out0_ready) begin
                out0_valid <= 1'b0;
            end
            if (accept && head == SEL_DATA) begin
                out1_valid <= 1'b1;
                out1_data  <= rsp_data;
            end else if (out1_ready) begin
                out1_valid <= 1'b0;
            end
        end
    end

`ifdef MEM_RSP_DEMUX_CHECK_EN
    logic overflow;
    logic spurious;
    logic error_q;

    assign overflow = req_fire && tag_full && !accept;
    assign spurious = rsp_valid && fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       error_q <= 1'b0;
        else if (overflow || spurious) error_q <= 1'b1;
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rsp_demux.sv
// Directed bench for mem_rsp_demux with a tag model and per-port expected-data scoreboard.
module tb_mem_rsp_demux;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef MEM_RSP_DEMUX_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_fire;
    logic          req_sel;
    logic          tag_full;
    logic          rsp_valid;
    logic [N-1:0]  rsp_data;
    logic          rsp_ready;
    logic          out0_valid;
    logic [N-1:0]  out0_data;
    logic          out0_ready;
    logic          out1_valid;
    logic [N-1:0]  out1_data;
    logic          out1_ready;
    logic [CW-1:0] outstanding;
    logic          error;

    int n_tests = 0;
    int n_fail  = 0;

    logic         mtags [$];
    logic [N-1:0] exp0  [$];
    logic [N-1:0] exp1  [$];

    always #5 clk = ~clk;

    mem_rsp_demux #(.n(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_fire    (req_fire),
        .req_sel     (req_sel),
        .tag_full    (tag_full),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_ready   (rsp_ready),
        .out0_valid  (out0_valid),
        .out0_data   (out0_data),
        .out0_ready  (out0_ready),
        .out1_valid  (out1_valid),
        .out1_data   (out1_data),
        .out1_ready  (out1_ready),
        .outstanding (outstanding),
        .error       (error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic s);
        req_fire = 1'b1;
        req_sel  = s;
        tick();
        req_fire = 1'b0;
        if (mtags.size() < DEPTH) mtags.push_back(s);
    endtask

    // Present one response, wait (bounded) for the handshake, and log where it should land.
    task automatic respond(input logic [N-1:0] d);
        int  i;
        logic s;
        rsp_valid = 1'b1;
        rsp_data  = d;
        i = 0;
        @(negedge clk);
        while (!rsp_ready && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("rsp_ready_wait", rsp_ready, 1);
        if (rsp_ready && mtags.size() > 0) begin
            s = mtags.pop_front();
            if (s) exp1.push_back(d);
            else   exp0.push_back(d);
        end
        tick();
        rsp_valid = 1'b0;
    endtask

    // Each negedge with valid&&ready is a transfer at the coming posedge.
    always @(negedge clk) begin
        logic [N-1:0] e;
        if (!rst) begin
            if (out0_valid && out0_ready) begin
                if (exp0.size() == 0) check("out0_unexpected", out0_data, 64'hDEAD);
                else begin
                    e = exp0.pop_front();
                    check("out0_data_sb", out0_data, e);
                end
            end
            if (out1_valid && out1_ready) begin
                if (exp1.size() == 0) check("out1_unexpected", out1_data, 64'hDEAD);
                else begin
                    e = exp1.pop_front();
                    check("out1_data_sb", out1_data, e);
                end
            end
        end
    end

    initial begin
        logic s;
        rst = 1'b1; req_fire = 1'b0; req_sel = 1'b0;
        rsp_valid = 1'b0; rsp_data = '0; out0_ready = 1'b1; out1_ready = 1'b1;
        tick(); tick();
        check("rst_out0_valid", out0_valid, 0);
        check("rst_out1_valid", out1_valid, 0);
        check("rst_out0_data", out0_data, 0);
        check("rst_out1_data", out1_data, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_tag_full", tag_full, 0);
        check("rst_rsp_ready", rsp_ready, 0);
        check("rst_error", error, 0);
        rst = 1'b0;
        tick(); tick();
        check("idle_outstanding", outstanding, 0);
        check("idle_rsp_ready", rsp_ready, 0);

        // In-order routing: tags 0,1,0.
        push_req(1'b0); push_req(1'b1); push_req(1'b0);
        check("three_outstanding", outstanding, 3);
        respond(32'hA1);
        check("a1_out0_valid", out0_valid, 1);
        check("a1_out0_data", out0_data, 32'hA1);
        check("a1_out1_valid", out1_valid, 0);
        respond(32'hB2);
        check("b2_out1_valid", out1_valid, 1);
        check("b2_out1_data", out1_data, 32'hB2);
        respond(32'hC3);
        check("c3_out0_data", out0_data, 32'hC3);
        check("drain_outstanding", outstanding, 0);
        tick();

        // Fill, then push and pop together while full.
        push_req(1'b0); push_req(1'b1); push_req(1'b0); push_req(1'b1);
        check("fill_tag_full", tag_full, 1);
        check("fill_outstanding", outstanding, 4);
        req_fire = 1'b1; req_sel = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hD4;
        @(negedge clk);
        check("full_pp_rsp_ready", rsp_ready, 1);
        s = mtags.pop_front();
        if (s) exp1.push_back(32'hD4); else exp0.push_back(32'hD4);
        mtags.push_back(1'b0);
        tick();
        req_fire = 1'b0; rsp_valid = 1'b0;
        check("full_pp_outstanding", outstanding, 4);
        check("full_pp_tag_full", tag_full, 1);
        check("full_pp_error", error, 0);
        check("full_pp_out0_data", out0_data, 32'hD4);
        respond(32'h11); respond(32'h12); respond(32'h13); respond(32'h14);
        check("drain2_outstanding", outstanding, 0);
        tick();

        // Backpressure on port 1 with a response waiting at the head.
        push_req(1'b1); push_req(1'b1);
        out1_ready = 1'b0;
        respond(32'hE5);
        rsp_valid = 1'b1; rsp_data = 32'hF6;
        @(negedge clk);
        check("bp_rsp_ready_low", rsp_ready, 0);
        tick(); tick();
        check("bp_out1_valid", out1_valid, 1);
        check("bp_out1_data_held", out1_data, 32'hE5);
        check("bp_outstanding", outstanding, 1);
        out1_ready = 1'b1;
        @(negedge clk);
        check("bp_release_rsp_ready", rsp_ready, 1);
        mtags.pop_front();
        exp1.push_back(32'hF6);
        tick();
        rsp_valid = 1'b0;
        check("bp_no_gap_valid", out1_valid, 1);
        check("bp_new_data", out1_data, 32'hF6);
        tick();
        check("bp_drained_valid", out1_valid, 0);

        // Back-to-back to port 1.
        push_req(1'b1); push_req(1'b1);
        respond(32'h77);
        check("b2b_first_valid", out1_valid, 1);
        check("b2b_first_data", out1_data, 32'h77);
        respond(32'h88);
        check("b2b_second_valid", out1_valid, 1);
        check("b2b_second_data", out1_data, 32'h88);
        tick();
        check("b2b_end_valid", out1_valid, 0);

        // Reset with two tags outstanding and port 1 holding data.
        out1_ready = 1'b0;
        push_req(1'b1); push_req(1'b1); push_req(1'b1);
        respond(32'h99);
        check("mid_pre_outstanding", outstanding, 2);
        check("mid_pre_out1_valid", out1_valid, 1);
        rst = 1'b1;
        mtags.delete(); exp0.delete(); exp1.delete();
        tick();
        check("mid_rst_outstanding", outstanding, 0);
        check("mid_rst_out1_valid", out1_valid, 0);
        check("mid_rst_out1_data", out1_data, 0);
        rst = 1'b0; out1_ready = 1'b1;
        tick();

        // Spurious response with no tags outstanding.
        rsp_valid = 1'b1; rsp_data = 32'h55;
        @(negedge clk);
        check("spur_rsp_ready", rsp_ready, 0);
        tick();
        rsp_valid = 1'b0;
        check("spur_error", error, ERR_EXP);
        check("spur_outstanding", outstanding, 0);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        check("err_cleared", error, 0);

        // Overflow push.
        push_req(1'b0); push_req(1'b1); push_req(1'b0); push_req(1'b1);
        check("ovf_error_before", error, 0);
        push_req(1'b0);
        check("ovf_outstanding", outstanding, 4);
        check("ovf_error", error, ERR_EXP);
        respond(32'h21); respond(32'h22); respond(32'h23); respond(32'h24);
        check("ovf_drain", outstanding, 0);
        tick(); tick();
        check("sb_exp0_empty", exp0.size(), 0);
        check("sb_exp1_empty", exp1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
